pipe_ctrl_gen: RTL

- Parametrised pipeline hazard controller for the yadan core; successor to the fixed 5-stage stall/flush controller.
- Resolves per-stage stall requests, branch redirects and trap redirects into per-stage stall/flush vectors. Vectors are produced combinationally, in the same cycle as the requests.
- Adds a flush-hold FSM that discards in-flight fetches on multi-cycle buses, saturating performance counters, and a stuck-freeze watchdog.
- Sits between the stage modules and the pipeline registers. Bit 0 of each vector is the PC; bit s is the pipeline register feeding stage s.

---
 rtl/pipe_ctrl_gen.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_gen.sv
// Pipeline hazard controller: resolves stall, branch and trap requests into per-stage
// stall/flush vectors, with flush-hold FSM, saturating perf counters and freeze watchdog.
module pipe_ctrl_gen #(
  parameter int STAGES     = 5,
  parameter int BR_STAGE   = 3,
  parameter int IRQ_STAGE  = 2,
  parameter int FLUSH_HOLD = 1,
  parameter int CNT_W      = 32,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-2:0] stallreq_i,
  input  logic              stallreq_irq_i,
  input  logic              branch_flag_i,
  input  logic              trap_flag_i,
  output logic [STAGES-1:0] stalled_o,
  output logic [STAGES-1:0] flush_o,
  output logic [CNT_W-1:0]  stall_cycles_o,
  output logic [CNT_W-1:0]  redirect_cnt_o,
  output logic              wdog_o,
  input  logic              wdog_clr_i
);

  localparam int RUN_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [3:0] HOLD_INIT = 4'(FLUSH_HOLD - 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(WDOG_LIMIT);
  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(WDOG_LIMIT - 1);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e            state_q, state_d;
  logic [3:0]        hcnt_q, hcnt_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  redirect_cnt_q, redirect_cnt_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              wdog_q, wdog_d;

  logic              redirect;
  logic              freeze;
  logic              force_flush;
  logic              found;
  int                hi;
  logic [STAGES-1:0] row_stall;
  logic [STAGES-1:0] row_flush;

  // Priority resolution: trap, branch, freeze, then the deepest effective stall request.
  always_comb begin
    redirect  = trap_flag_i | branch_flag_i;
    freeze    = !redirect && stallreq_i[STAGES-2];
    row_stall = '0;
    row_flush = '0;
    found     = 1'b0;
    hi        = 0;
    if (trap_flag_i) begin
      row_stall[0] = 1'b1;
      row_flush    = {{(STAGES-1){1'b1}}, 1'b0};
    end else if (branch_flag_i) begin
      row_stall[0] = 1'b1;
      for (int i = 1; i < STAGES; i++) begin
        if (i < BR_STAGE) row_flush[i] = 1'b1;
      end
    end else if (stallreq_i[STAGES-2]) begin
      row_stall = '1;
    end else begin
      for (int s = 1; s <= STAGES-2; s++) begin
        if (stallreq_i[s-1] || (s == IRQ_STAGE && stallreq_irq_i)) begin
          found = 1'b1;
          hi    = s;
        end
      end
      if (found) begin
        for (int i = 0; i < STAGES; i++) begin
          if (i < hi)  row_stall[i] = 1'b1;
          if (i == hi) row_flush[i] = 1'b1;
        end
      end
    end
  end

  // A hold cycle bubbles the fetch register; a fresh redirect supplies its own row.
  always_comb begin
    force_flush = (state_q == HOLD) && !redirect;
    stalled_o   = row_stall;
    flush_o     = row_flush;
    if (force_flush) begin
      flush_o[1]   = 1'b1;
      stalled_o[1] = 1'b0;
    end
    if (rst) begin
      stalled_o = '0;
      flush_o   = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    if (redirect) begin
      hcnt_d  = HOLD_INIT;
      state_d = (HOLD_INIT != 4'd0) ? HOLD : IDLE;
    end else if (state_q == HOLD && !freeze) begin
      hcnt_d = hcnt_q - 4'd1;
      if (hcnt_d == 4'd0) state_d = IDLE;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    redirect_cnt_d = redirect_cnt_q;
    if ((|stalled_o) && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (redirect && (redirect_cnt_q != '1))     redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
  end

  // The run counter parks at the limit; wdog is sticky until explicitly cleared.
  always_comb begin
    run_d  = run_q;
    wdog_d = wdog_q;
    if (!freeze) begin
      run_d = '0;
    end else if (run_q != RUN_LIMIT) begin
      run_d = run_q + RUN_W'(1);
    end
    if (freeze && run_q == RUN_LAST) wdog_d = 1'b1;
    if (wdog_clr_i) begin
      run_d  = '0;
      wdog_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      hcnt_q         <= '0;
      stall_cycles_q <= '0;
      redirect_cnt_q <= '0;
      run_q          <= '0;
      wdog_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      hcnt_q         <= hcnt_d;
      stall_cycles_q <= stall_cycles_d;
      redirect_cnt_q <= redirect_cnt_d;
      run_q          <= run_d;
      wdog_q         <= wdog_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign redirect_cnt_o = redirect_cnt_q;
  assign wdog_o         = wdog_q;

endmodule
